mips_dmem_io: RTL and testbench
===============================

MIPS_DMEM_IO -- requirements
Module: mips_dmem_io

Interface
REQ-001 Parameter DEPTH, default 64: RAM size in 32-bit words; power of two, 4..1024.
REQ-002 Parameter TW, default 32: timer counter width, 8..32; zero-extended on read.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 reset  input  1: synchronous, active-low reset, sampled on the rising clk edge.
REQ-005 memwrite  input  1: store strobe from the CPU, one write per asserted cycle.
REQ-006 addr  input  32: byte address, driven from the CPU ALU result.
REQ-007 writedata  input  32: store data.
REQ-008 readdata  output  32: load data, combinational from addr in the same cycle.
REQ-009 leds  output  8: LED register contents.
REQ-010 tmr_flag  output  1: timer done flag, level.

Function
REQ-011 Map: addr[31:16]==0x0000 selects RAM, word index addr[log2(DEPTH)+1:2], with aliasing above DEPTH.
REQ-012 Map: 0xFFFF0000 LED (RW, bits[7:0]); 0xFFFF0004 COUNT (RO); 0xFFFF0008 CMP (RW); 0xFFFF000C CTRL (RW); all other addresses unmapped.
REQ-013 addr[1:0] is ignored everywhere; only whole-word access is supported.
REQ-014 RAM write takes effect at the edge where memwrite=1; a read of the same word in that cycle returns the old value.
REQ-015 Unmapped reads return 0; unmapped writes and writes to COUNT are discarded.
REQ-016 CTRL layout: bit0 EN, bit1 AUTO, bit2 DONE; reads return {29'b0, DONE, AUTO, EN}.
REQ-017 Timer FSM states: IDLE, RUN, DONE.
REQ-018 IDLE->RUN on a CTRL write with EN=1; COUNT is cleared to 0 on that edge.
REQ-019 RUN: COUNT increments by 1 per tick.
REQ-020 When COUNT==CMP at a tick, DONE is set. With AUTO=1, COUNT is set to 0 and the FSM stays in RUN; with AUTO=0, the FSM moves to DONE and COUNT holds.
REQ-021 A CTRL write with EN=0 from any state moves the FSM to IDLE; COUNT holds.
REQ-022 In DONE, a CTRL write with EN=1 restarts: COUNT is cleared to 0 and the FSM moves to RUN.
REQ-023 The DONE bit is write-1-to-clear; writing 0 leaves it unchanged; tmr_flag equals DONE.
REQ-024 Simultaneous DONE set (match) and W1C in the same cycle: set wins, and DONE=1 afterwards.
REQ-025 A CMP write in the same cycle as a match: the compare uses the old CMP; the new CMP applies from the next cycle.
REQ-026 COUNT wraps from all-ones to 0 without setting DONE unless it matches CMP.

Reset
REQ-027 While reset=0 at an edge: LED=0, COUNT=0, CMP=all-ones, CTRL=0, FSM=IDLE, prescale counter=0.
REQ-028 Reset mid-RUN aborts the timer immediately; RAM contents are not reset; readdata stays combinational during reset.

Configuration
REQ-029 With MIPS_DMEM_IO_PRESCALE_EN defined: PRE register at 0xFFFF0010 (RW, 16 bits, reset 0); a tick occurs every PRE+1 clk cycles while in RUN; the prescale counter clears on entry to RUN.
REQ-030 Without MIPS_DMEM_IO_PRESCALE_EN: a tick occurs every clk cycle in RUN; 0xFFFF0010 is unmapped and reads 0.

Structure
REQ-031 Package mips_io_pkg holds the address constants, CTRL bit indices, and the timer-state enum (IDLE, RUN, DONE).
REQ-032 Sub-module io_timer holds the FSM, COUNT, CMP, CTRL, and PRE; the top level holds the RAM, LED, address decode, and read mux.

Verification
REQ-033 Write 0x1234_5678 to 0x40, then read 0x40 and 0x43 -> both return 0x1234_5678; read 0x40+4*DEPTH -> returns the alias value.
REQ-034 Write LED 0x1FF, then read LED -> leds=0xFF and readdata=0xFF; read 0xFFFF0020 -> returns 0.
REQ-035 CMP=5, CTRL=0x1 -> tmr_flag rises 6 cycles after the write edge; COUNT holds at 5; FSM=DONE; W1C 0x4 -> tmr_flag=0.
REQ-036 CMP=3, CTRL=0x3 -> tmr_flag set; COUNT sequence 1,2,3,0,1; FSM stays in RUN; W1C issued in a match cycle -> tmr_flag stays 1.
REQ-037 reset=0 asserted mid-RUN with COUNT=2 -> next cycle COUNT=0, FSM=IDLE, leds=0, and the RAM word written earlier is still readable.
REQ-038 With MIPS_DMEM_IO_PRESCALE_EN, PRE=2, CMP=2 -> tmr_flag rises 9 cycles after the start edge; without the macro, a write to 0x10 followed by a read returns 0.

Source files
------------

// File: rtl/mips_io_pkg.sv
// Shared constants for the MIPS data-memory / IO block: the IO address map,
// CTRL register bit positions and the timer state encoding.
package mips_io_pkg;

  localparam logic [31:0] ADDR_LED   = 32'hFFFF_0000;
  localparam logic [31:0] ADDR_COUNT = 32'hFFFF_0004;
  localparam logic [31:0] ADDR_CMP   = 32'hFFFF_0008;
  localparam logic [31:0] ADDR_CTRL  = 32'hFFFF_000C;
  localparam logic [31:0] ADDR_PRE   = 32'hFFFF_0010;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_DONE = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_e;

  // True when a byte address hits the given IO word (addr[1:0] ignored).
  function automatic logic io_hit(input logic [31:0] a, input logic [31:0] reg_addr);
    return a[31:2] == reg_addr[31:2];
  endfunction

endpackage

// File: rtl/io_timer.sv
// Memory-mapped timer: COUNT / CMP / CTRL registers and the run-control FSM.
// Optional prescaler enabled by MIPS_DMEM_IO_PRESCALE_EN.
//
// state | meaning
// IDLE  | stopped, COUNT frozen, waiting for a CTRL write with EN=1
// RUN   | COUNT advances once per tick, compared against CMP
// DONE  | one-shot match reached, COUNT holds until restarted or stopped
module io_timer import mips_io_pkg::*; #(
  parameter int TW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_cmp,
  input  logic          wr_ctrl,
`ifdef MIPS_DMEM_IO_PRESCALE_EN
  input  logic          wr_pre,
  output logic [15:0]   pre_rd,
`endif
  input  logic [31:0]   wdata,
  output logic [TW-1:0] count,
  output logic [TW-1:0] cmp,
  output logic [2:0]    ctrl,
  output logic          flag
);

  timer_state_e state, state_nxt;
  logic [TW-1:0] count_nxt;
  logic          en, auto, done, done_nxt;
  logic          tick, match, restart;
  logic          unused_wdata;

  assign unused_wdata = ^wdata;

`ifdef MIPS_DMEM_IO_PRESCALE_EN
  logic [15:0] pre, pre_cnt, pre_cnt_nxt;

  assign pre_rd = pre;
  assign tick   = (state == RUN) && (pre_cnt == pre);

  // Prescale counter restarts with the timer and wraps at PRE.
  always_comb begin
    pre_cnt_nxt = pre_cnt;
    if (restart) pre_cnt_nxt = '0;
    else if (state == RUN) pre_cnt_nxt = tick ? 16'd0 : pre_cnt + 16'd1;
  end

  // Prescale register and counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pre     <= '0;
      pre_cnt <= '0;
    end else begin
      if (wr_pre) pre <= wdata[15:0];
      pre_cnt <= pre_cnt_nxt;
    end
  end
`else
  assign tick = (state == RUN);
`endif

  assign match = tick && (count == cmp);
  assign ctrl  = {done, auto, en};
  assign flag  = done;

  // Next-state and COUNT update; a CTRL write with EN=0 always stops the timer.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    restart   = 1'b0;
    if (wr_ctrl && !wdata[CTRL_EN]) begin
      state_nxt = IDLE;
    end else if (wr_ctrl && wdata[CTRL_EN] && state != RUN) begin
      state_nxt = RUN;
      count_nxt = '0;
      restart   = 1'b1;
    end else if (tick) begin
      if (match) begin
        if (auto) count_nxt = '0;
        else      state_nxt = DONE;
      end else begin
        count_nxt = count + TW'(1);
      end
    end
  end

  // DONE is write-1-to-clear, but a match in the same cycle takes priority.
  always_comb begin
    done_nxt = done;
    if (match) done_nxt = 1'b1;
    else if (wr_ctrl && wdata[CTRL_DONE]) done_nxt = 1'b0;
  end

  // State, COUNT and register-file updates.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      cmp   <= '1;
      en    <= 1'b0;
      auto  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      done  <= done_nxt;
      if (wr_cmp) cmp <= wdata[TW-1:0];
      if (wr_ctrl) begin
        en   <= wdata[CTRL_EN];
        auto <= wdata[CTRL_AUTO];
      end
    end
  end

endmodule

// File: rtl/mips_dmem_io.sv
// Data memory plus memory-mapped IO for a single-cycle MIPS core:
// word RAM at 0x0000_xxxx, LED register and timer at 0xFFFF_00xx.
// Optional timer prescaler enabled by MIPS_DMEM_IO_PRESCALE_EN.
module mips_dmem_io import mips_io_pkg::*; #(
  parameter int DEPTH = 64,
  parameter int TW    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  leds,
  output logic        tmr_flag
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] widx;
  logic          ram_sel, sel_led, sel_count, sel_cmp, sel_ctrl;
  logic [7:0]    led_q;
  logic [TW-1:0] count, cmp;
  logic [2:0]    ctrl;
  logic          unused_addr;

  assign unused_addr = ^addr[1:0];
  assign widx        = addr[AW+1:2];
  assign ram_sel     = (addr[31:16] == 16'h0000);
  assign sel_led     = io_hit(addr, ADDR_LED);
  assign sel_count   = io_hit(addr, ADDR_COUNT);
  assign sel_cmp     = io_hit(addr, ADDR_CMP);
  assign sel_ctrl    = io_hit(addr, ADDR_CTRL);
  assign leds        = led_q;

`ifdef MIPS_DMEM_IO_PRESCALE_EN
  logic        sel_pre;
  logic [15:0] pre_rd;
  assign sel_pre = io_hit(addr, ADDR_PRE);
`endif

  io_timer #(.TW(TW)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_cmp  (memwrite && sel_cmp),
    .wr_ctrl (memwrite && sel_ctrl),
`ifdef MIPS_DMEM_IO_PRESCALE_EN
    .wr_pre  (memwrite && sel_pre),
    .pre_rd  (pre_rd),
`endif
    .wdata   (writedata),
    .count   (count),
    .cmp     (cmp),
    .ctrl    (ctrl),
    .flag    (tmr_flag)
  );

  // RAM is deliberately not reset; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (memwrite && ram_sel) mem[widx] <= writedata;
  end

  // LED register.
  always_ff @(posedge clk) begin
    if (!reset) led_q <= '0;
    else if (memwrite && sel_led) led_q <= writedata[7:0];
  end

  // Combinational read mux; unmapped addresses read as zero.
  always_comb begin
    readdata = '0;
    if (ram_sel)        readdata = mem[widx];
    else if (sel_led)   readdata = {24'h0, led_q};
    else if (sel_count) readdata = 32'(count);
    else if (sel_cmp)   readdata = 32'(cmp);
    else if (sel_ctrl)  readdata = {29'h0, ctrl};
`ifdef MIPS_DMEM_IO_PRESCALE_EN
    else if (sel_pre)   readdata = {16'h0, pre_rd};
`endif
  end

endmodule

// File: tb/tb_mips_dmem_io.sv
// Directed bench for mips_dmem_io: expected values are queued as stimulus is
// driven and popped when the corresponding DUT output is sampled.
module tb_mips_dmem_io;
  import mips_io_pkg::*;

  logic        clk = 1'b0;
  logic        reset, memwrite;
  logic [31:0] addr, writedata, readdata;
  logic [7:0]  leds;
  logic        tmr_flag;

  int n_pass = 0, n_fail = 0, n_total = 0;
  logic [31:0] exp_q[$];

  mips_dmem_io #(.DEPTH(64), .TW(32)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr),
    .writedata(writedata), .readdata(readdata), .leds(leds), .tmr_flag(tmr_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_total++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h expected <none queued>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; writedata = d; memwrite = 1'b1;
    @(posedge clk); #1;
    memwrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    addr = a; #1;
  endtask

  function automatic logic [31:0] st();
    return 32'(dut.u_timer.state);
  endfunction

  initial begin
    reset = 1'b0; memwrite = 1'b0; addr = '0; writedata = '0;
    repeat (2) @(posedge clk); #1;

    // Reset values
    push(32'h0);         check("rst_leds", 32'(leds));
    push(32'h0);         check("rst_flag", 32'(tmr_flag));
    push(32'hFFFF_FFFF); rd(ADDR_CMP);   check("rst_cmp", readdata);
    push(32'h0);         rd(ADDR_CTRL);  check("rst_ctrl", readdata);
    push(32'h0);         rd(ADDR_COUNT); check("rst_count", readdata);
    push(32'(IDLE));     check("rst_state", st());
    reset = 1'b1;
    @(posedge clk); #1;

    // COUNT is read-only
    wr(ADDR_COUNT, 32'd7);
    push(32'h0); rd(ADDR_COUNT); check("count_ro", readdata);

    // RAM write/read, byte-offset ignore, aliasing
    wr(32'h40, 32'h1234_5678);
    push(32'h1234_5678); rd(32'h40);          check("ram_rd", readdata);
    push(32'h1234_5678); rd(32'h43);          check("ram_rd_off", readdata);
    push(32'h1234_5678); rd(32'h40 + 4 * 64); check("ram_alias", readdata);

    // Read during write cycle returns the old word
    wr(32'h44, 32'hAAAA_0001);
    push(32'hAAAA_0001); push(32'hBBBB_0002);
    addr = 32'h44; writedata = 32'hBBBB_0002; memwrite = 1'b1; #1;
    check("ram_rd_old", readdata);
    @(posedge clk); #1; memwrite = 1'b0; #1;
    check("ram_rd_new", readdata);

    // LED register and unmapped read
    wr(ADDR_LED, 32'h1FF);
    push(32'hFF); check("leds_out", 32'(leds));
    push(32'hFF); rd(ADDR_LED); check("led_rd", readdata);
    push(32'h0);  rd(32'hFFFF_0020); check("unmapped_rd", readdata);

    // One-shot: CMP=5, EN=1 -> flag rises 6 cycles after the write edge
    wr(ADDR_CMP, 32'd5);
    wr(ADDR_CTRL, 32'h1);
    repeat (5) @(posedge clk); #1;
    push(32'h0); check("os_flag_e5", 32'(tmr_flag));
    push(32'd5); rd(ADDR_COUNT); check("os_count_e5", readdata);
    @(posedge clk); #1;
    push(32'h1);      check("os_flag_e6", 32'(tmr_flag));
    push(32'(DONE));  check("os_state", st());
    @(posedge clk); #1;
    push(32'd5); rd(ADDR_COUNT); check("os_count_hold", readdata);
    push(32'h5); rd(ADDR_CTRL);  check("os_ctrl_rd", readdata);
    // Restart from DONE: COUNT cleared, DONE bit untouched
    wr(ADDR_CTRL, 32'h1);
    push(32'(RUN)); check("os_restart_state", st());
    push(32'd0);    rd(ADDR_COUNT); check("os_restart_count", readdata);
    push(32'h1);    check("os_restart_flag", 32'(tmr_flag));
    // Stop + W1C
    wr(ADDR_CTRL, 32'h4);
    push(32'h0);     check("os_w1c_flag", 32'(tmr_flag));
    push(32'(IDLE)); check("os_stop_state", st());
    push(32'd0);     rd(ADDR_COUNT); check("os_stop_count", readdata);

    // Auto-reload: CMP=3, EN|AUTO -> COUNT 1,2,3,0,1
    wr(ADDR_CMP, 32'd3);
    wr(ADDR_CTRL, 32'h3);
    for (int k = 1; k <= 5; k++) begin
      logic [31:0] seq [5];
      seq = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
      @(posedge clk); #1;
      push(seq[k-1]); rd(ADDR_COUNT); check($sformatf("auto_count_%0d", k), readdata);
      push((k >= 4) ? 32'h1 : 32'h0); check($sformatf("auto_flag_%0d", k), 32'(tmr_flag));
    end
    push(32'(RUN)); check("auto_state", st());
    repeat (2) @(posedge clk); #1;
    wr(ADDR_CTRL, 32'h7);           // W1C lands on the match edge
    push(32'h1); check("auto_set_wins", 32'(tmr_flag));
    push(32'd0); rd(ADDR_COUNT); check("auto_reload", readdata);
    wr(ADDR_CTRL, 32'h7);           // W1C on a non-match edge
    push(32'h0); check("auto_w1c", 32'(tmr_flag));

    // Reset mid-RUN with COUNT=2
    wr(ADDR_CTRL, 32'h4);
    wr(ADDR_CMP, 32'd10);
    wr(ADDR_CTRL, 32'h1);
    repeat (2) @(posedge clk); #1;
    push(32'd2); rd(ADDR_COUNT); check("pre_rst_count", readdata);
    reset = 1'b0;
    @(posedge clk); #1;
    push(32'd0);         rd(ADDR_COUNT); check("mid_rst_count", readdata);
    push(32'(IDLE));     check("mid_rst_state", st());
    push(32'h0);         check("mid_rst_leds", 32'(leds));
    push(32'h1234_5678); rd(32'h40); check("mid_rst_ram", readdata);
    push(32'hFFFF_FFFF); rd(ADDR_CMP); check("mid_rst_cmp", readdata);
    reset = 1'b1;
    @(posedge clk); #1;

`ifdef MIPS_DMEM_IO_PRESCALE_EN
    wr(ADDR_PRE, 32'd2);
    push(32'd2); rd(ADDR_PRE); check("pre_rd", readdata);
    wr(ADDR_CMP, 32'd2);
    wr(ADDR_CTRL, 32'h1);
    repeat (8) @(posedge clk); #1;
    push(32'h0); check("pre_flag_e8", 32'(tmr_flag));
    @(posedge clk); #1;
    push(32'h1); check("pre_flag_e9", 32'(tmr_flag));
`else
    wr(ADDR_PRE, 32'h1234);
    push(32'h0); rd(ADDR_PRE); check("no_pre_rd", readdata);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
